// File: rtl/core_dbg_ctrl_if.sv
// rtl/core_dbg_ctrl_if.sv - debugger register access bus (strobe + one-cycle read response)
interface core_dbg_ctrl_if #(
  parameter int DBG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
);
  logic                      dbg_req;
  logic                      dbg_wr_rd;
  logic [DBG_ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0]     dbg_wdata;
  logic [DATA_WIDTH-1:0]     dbg_rdata;
  logic                      dbg_rd_ready;

  // Debugger side: issues strobes, receives read data
  modport master (
    output dbg_req, dbg_wr_rd, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_rd_ready
  );

  // Controller side: decodes strobes, returns read data
  modport slave (
    input  dbg_req, dbg_wr_rd, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_rd_ready
  );
endinterface

// File: rtl/core_dbg_ctrl.sv
// rtl/core_dbg_ctrl.sv - core debug halt/resume/instruction-injection controller; optional CORE_DBG_ITR_TIMEOUT_EN
module core_dbg_ctrl #(
  parameter int DBG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int ITR_TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dbg_on_rst,
  core_dbg_ctrl_if.slave        dbg,
  output logic                  fetch_halt,
  output logic                  halted,
  input  logic                  pipe_empty,
  output logic                  itr_valid,
  output logic [DATA_WIDTH-1:0] itr_insn,
  input  logic                  itr_done,
  input  logic                  dtr_wr_en,
  input  logic [DATA_WIDTH-1:0] dtr_wr_val
);

  localparam logic [DBG_ADDR_WIDTH-1:0] ADDR_CTRL   = DBG_ADDR_WIDTH'(0);
  localparam logic [DBG_ADDR_WIDTH-1:0] ADDR_STATUS = DBG_ADDR_WIDTH'(1);
  localparam logic [DBG_ADDR_WIDTH-1:0] ADDR_DTR    = DBG_ADDR_WIDTH'(2);
  localparam logic [DBG_ADDR_WIDTH-1:0] ADDR_ITR3   = DBG_ADDR_WIDTH'(3);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED,
    ST_ITR_EXEC
  } state_t;

  state_t                state, state_next;
  logic                  wr_strobe, rd_strobe;
  logic                  wr_ctrl, wr_status, wr_dtr, wr_itr;
  logic                  launch, itr_drop;
  logic [DATA_WIDTH-1:0] dtr;
  logic                  itr_ovf;
  logic                  itr_to;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] rd_mux;

`ifdef CORE_DBG_ITR_TIMEOUT_EN
  localparam int                CNT_W   = $clog2(ITR_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(ITR_TIMEOUT - 1);
  logic [CNT_W-1:0]             itr_cnt;
  logic                         to_hit;
`else
  // No watchdog: ITR_TIMEOUT only sanity-checked so the parameter stays meaningful
  if (ITR_TIMEOUT < 1) begin : g_itr_timeout_ignored
  end
  assign itr_to = 1'b0;
`endif

  // Decode the one-cycle access strobe into per-register write/read pulses
  always_comb begin
    wr_strobe = dbg.dbg_req && dbg.dbg_wr_rd;
    rd_strobe = dbg.dbg_req && !dbg.dbg_wr_rd;
    wr_ctrl   = wr_strobe && (dbg.dbg_addr == ADDR_CTRL);
    wr_status = wr_strobe && (dbg.dbg_addr == ADDR_STATUS);
    wr_dtr    = wr_strobe && (dbg.dbg_addr == ADDR_DTR);
    wr_itr    = wr_strobe && (dbg.dbg_addr == ADDR_ITR3);
  end

  // Next-state logic; CTRL writes outside RUN/HALTED are simply dropped
  always_comb begin
    state_next = state;
    launch     = 1'b0;
`ifdef CORE_DBG_ITR_TIMEOUT_EN
    to_hit     = 1'b0;
`endif
    case (state)
      ST_RUN: begin
        if (wr_ctrl && dbg.dbg_wdata[0]) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipe_empty) state_next = ST_HALTED;
      end
      ST_HALTED: begin
        if (wr_itr) begin
          state_next = ST_ITR_EXEC;
          launch     = 1'b1;
        end else if (wr_ctrl && dbg.dbg_wdata[1]) begin
          state_next = ST_RUN;
        end
      end
      ST_ITR_EXEC: begin
        if (itr_done) begin
          state_next = ST_HALTED;
`ifdef CORE_DBG_ITR_TIMEOUT_EN
        end else if (itr_cnt == TO_LAST) begin
          state_next = ST_HALTED;
          to_hit     = 1'b1;
`endif
        end
      end
      default: state_next = ST_RUN;
    endcase
    itr_drop = wr_itr && (state != ST_HALTED);
  end

  // State register; reset lands directly in HALTED when debug-on-reset is requested
  always_ff @(posedge clk) begin
    if (rst) state <= dbg_on_rst ? ST_HALTED : ST_RUN;
    else     state <= state_next;
  end

  // Core-facing controls registered from next state so they track the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_halt <= dbg_on_rst;
      halted     <= dbg_on_rst;
      itr_valid  <= 1'b0;
      itr_insn   <= '0;
    end else begin
      fetch_halt <= (state_next != ST_RUN);
      halted     <= (state_next == ST_HALTED) || (state_next == ST_ITR_EXEC);
      itr_valid  <= launch;
      if (launch) itr_insn <= dbg.dbg_wdata;
    end
  end

  // Data transfer register: the core's own write beats a same-cycle debugger write
  always_ff @(posedge clk) begin
    if (rst)            dtr <= '0;
    else if (dtr_wr_en) dtr <= dtr_wr_val;
    else if (wr_dtr)    dtr <= dbg.dbg_wdata;
  end

  // Overflow sticky: set by a dropped ITR3 write, cleared by writing 1 to STATUS[2]
  always_ff @(posedge clk) begin
    if (rst)                                  itr_ovf <= 1'b0;
    else if (itr_drop)                        itr_ovf <= 1'b1;
    else if (wr_status && dbg.dbg_wdata[2])   itr_ovf <= 1'b0;
  end

`ifdef CORE_DBG_ITR_TIMEOUT_EN
  // Timeout sticky: a timeout in the same cycle as a clear keeps the bit set
  always_ff @(posedge clk) begin
    if (rst)                                  itr_to <= 1'b0;
    else if (to_hit)                          itr_to <= 1'b1;
    else if (wr_status && dbg.dbg_wdata[3])   itr_to <= 1'b0;
  end

  // Watchdog counter: zeroed on launch, counts every cycle spent in ITR_EXEC
  always_ff @(posedge clk) begin
    if (rst)                        itr_cnt <= '0;
    else if (launch)                itr_cnt <= '0;
    else if (state == ST_ITR_EXEC)  itr_cnt <= itr_cnt + 1'b1;
  end
`endif

  // STATUS word and read-data mux; CTRL, ITR3 and unmapped addresses read as zero
  always_comb begin
    status_word    = '0;
    status_word[0] = halted;
    status_word[1] = (state == ST_ITR_EXEC);
    status_word[2] = itr_ovf;
    status_word[3] = itr_to;
    rd_mux         = '0;
    case (dbg.dbg_addr)
      ADDR_STATUS: rd_mux = status_word;
      ADDR_DTR:    rd_mux = dtr;
      default:     rd_mux = '0;
    endcase
  end

  // Read response one cycle after the strobe; data holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg.dbg_rdata    <= '0;
      dbg.dbg_rd_ready <= 1'b0;
    end else begin
      dbg.dbg_rd_ready <= rd_strobe;
      if (rd_strobe) dbg.dbg_rdata <= rd_mux;
    end
  end

endmodule
